spart_echo_ctrl: RTL and testbench
==================================

# spart_echo_ctrl

Parametrised successor to the SPART board driver. It programs the SPART baud divisor from `br_cfg` and reprograms it whenever `br_cfg` changes. Received bytes are buffered in an internal FIFO of configurable depth, and `mode` selects echo, uppercase-echo, sink or hold behaviour. It sits between the board switches/LEDs and the SPART register bus (`iocs`/`iorw`/`ioaddr`/`databus`) and performs at most one bus access per cycle.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; divisor table computed from it at elaboration.
- `DEPTH`, 8: FIFO entries, ≥2, need not be a power of 2.
- `DIV_W`, 16: divisor width, written as low byte then high byte; must be ≤16.
- `clk`  in  1  system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `br_cfg`  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- `mode`  in  2  00 echo, 01 uppercase echo, 10 sink (read, discard), 11 hold (buffer, no transmit).
- `clr_ovf`  in  1  clears sticky `ovf`.
- `rda`  in  1  SPART receive data available.
- `tbr`  in  1  SPART transmit buffer ready.
- `iocs`  out  1  bus access strobe, one cycle per access.
- `iorw`  out  1  1=read/bus released, 0=write.
- `ioaddr`  out  2  00 data, 10 divisor low, 11 divisor high.
- `databus`  inout  8  driven only when `iocs`=1 and `iorw`=0, else Z.
- `fifo_count`  out  $clog2(DEPTH+1)  current occupancy.
- `ovf`  out  1  sticky: byte received while FIFO full.
- `rx_total`  out  16  bytes read from SPART, wraps 0xFFFF→0.
- `cfg_valid`  out  1  divisor for current `cfg_q` fully written.

## Operation
- Divisor: `div(b) = (CLK_HZ + 8*b) / (16*b)`, integer division. At 50 MHz this gives 651, 326, 163, 81.
- Registered `cfg_q` latches `br_cfg` on the CFG_LO cycle. LO and HI bytes always come from the same `cfg_q`.
- States:
  - CFG_WAIT: `iocs`=0; go to CFG_LO when `tbr`=1.
  - CFG_LO: write `div[7:0]` at `ioaddr` 10; go to CFG_HI.
  - CFG_HI: write `div[DIV_W-1:8]`, zero-extended, at `ioaddr` 11; set `cfg_valid`; go to IDLE.
  - IDLE: evaluate the priority list below.
  - RD: `iocs`=1, `iorw`=1, `ioaddr`=00; go to GAP.
  - WR: `iocs`=1, `iorw`=0, `ioaddr`=00, `databus`=FIFO head; go to GAP.
  - GAP: `iocs`=0; go to IDLE. Gives the SPART one cycle to drop `rda`/`tbr`.
- IDLE priority, highest first:
  1. `br_cfg`≠`cfg_q` → clear `cfg_valid`, go to CFG_WAIT.
  2. `rda` → RD.
  3. `tbr` & FIFO non-empty & `mode`≠11 → WR.
  4. Otherwise stay in IDLE.
- A `br_cfg` change is acted on only in IDLE. An in-flight RD/WR/GAP completes first. FIFO contents are preserved across reprogramming.
- RD push rule, applied at the edge ending RD:
  - `rx_total` increments in every mode.
  - mode 10: byte discarded.
  - FIFO full: byte discarded and `ovf` set.
  - Otherwise pushed. In mode 01, 0x61–0x7A is stored minus 0x20; all other bytes are stored unchanged.
- WR pops at the edge ending WR.
- Push and pop never occur in the same cycle. Pointers wrap DEPTH-1→0. `fifo_count` never exceeds DEPTH and never underflows.
- `ovf`: `clr_ovf` clears it. If a set and `clr_ovf` coincide, set wins.
- Changing `mode` affects only subsequent decisions. Bytes already buffered keep their stored value.
- Outside CFG_LO/CFG_HI/RD/WR: `iocs`=0, `iorw`=1, `ioaddr`=00.

## Timing
- Reset values, effective from the first edge with `rst`=1:
  - state CFG_WAIT, `cfg_q`=00, `cfg_valid`=0.
  - `iocs`=0, `iorw`=1, `ioaddr`=00, `databus` Z.
  - FIFO empty, `fifo_count`=0, `ovf`=0, `rx_total`=0.
- A reset mid-access aborts the access. The partially programmed divisor is rewritten after reset.
- All outputs are registered or decoded from state only; there are no combinational paths from `rda`/`tbr` to `iocs`.
- Echo latency, with `rda` seen in IDLE at cycle 0 and `tbr`=1:
  - cycle 1: RD
  - cycle 2: GAP
  - cycle 3: IDLE
  - cycle 4: WR
  - The byte leaves on the bus at cycle 4.
- Minimum spacing between bus accesses is 3 cycles (access, GAP, IDLE). Divisor LO/HI are the exception: back-to-back.
- Configuration takes 3 cycles after `tbr` is seen (CFG_WAIT, CFG_LO, CFG_HI). `cfg_valid` rises on the cycle after CFG_HI.
- `fifo_count` and `rx_total` update on the cycle after RD/WR.

## Test plan
- Reset, `br_cfg`=00, `tbr`=1 → writes 0x8B@10 then 0x02@11 on consecutive cycles; `cfg_valid`=1 afterwards; `iocs` low otherwise.
- `mode`=00, `rda` pulse with byte 0x41 → RD, then WR of 0x41 4 cycles after `rda`; `rx_total`=1; `fifo_count` 0→1→0.
- `mode`=01, bytes 0x61, 0x7A, 0x5B → transmitted 0x41, 0x5A, 0x5B.
- `mode`=11, DEPTH+2 bytes received → `fifo_count`=DEPTH, `ovf`=1, `rx_total`=DEPTH+2, no writes. Switch to `mode`=00 → first DEPTH bytes drain in order. `clr_ovf` → `ovf`=0.
- Change `br_cfg` 00→11 while FIFO holds 3 bytes, with `rda` asserted in the same cycle → reprogram first (0x51@10, 0x00@11), then RD, then the 3 buffered bytes plus the new byte transmitted in order.
- Assert `rst` during WR with `fifo_count`=2 → next cycle `iocs`=0, `fifo_count`=0, state CFG_WAIT.

Source files
------------

// File: rtl/spart_echo_ctrl.sv
// spart_echo_ctrl: programs the SPART baud divisor and buffers received bytes for echo/uppercase/sink/hold.
// Revision 1.0
`default_nettype none

module spart_echo_ctrl #(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   br_cfg,
  input  logic [1:0]                   mode,
  input  logic                         clr_ovf,
  input  logic                         rda,
  input  logic                         tbr,
  output logic                         iocs,
  output logic                         iorw,
  output logic [1:0]                   ioaddr,
  inout  wire  [7:0]                   databus,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         ovf,
  output logic [15:0]                  rx_total,
  output logic                         cfg_valid
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [15:0] DIV_MASK = 16'((32'd1 << DIV_W) - 32'd1);

  function automatic logic [15:0] div_of(input int baud);
    int d;
    d = (CLK_HZ + 8 * baud) / (16 * baud);
    return 16'(d) & DIV_MASK;
  endfunction

  localparam logic [15:0] DIV_4800  = div_of(4800);
  localparam logic [15:0] DIV_9600  = div_of(9600);
  localparam logic [15:0] DIV_19200 = div_of(19200);
  localparam logic [15:0] DIV_38400 = div_of(38400);

  localparam logic [2:0] S_CFG_WAIT = 3'd0;
  localparam logic [2:0] S_CFG_LO   = 3'd1;
  localparam logic [2:0] S_CFG_HI   = 3'd2;
  localparam logic [2:0] S_IDLE     = 3'd3;
  localparam logic [2:0] S_RD       = 3'd4;
  localparam logic [2:0] S_WR       = 3'd5;
  localparam logic [2:0] S_GAP      = 3'd6;

  logic [2:0]       state;
  logic [1:0]       cfg_q;
  logic [15:0]      div_sel;
  logic [7:0]       dout;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             push;
  logic [7:0]       push_data;

  assign full = (fifo_count == CNT_W'(DEPTH));
  assign push = (state == S_RD) && (mode != 2'b10) && !full;

  always_comb begin
    div_sel = DIV_4800;
    case (cfg_q)
      2'b00:   div_sel = DIV_4800;
      2'b01:   div_sel = DIV_9600;
      2'b10:   div_sel = DIV_19200;
      default: div_sel = DIV_38400;
    endcase
  end

  // Case folding happens on the way in, so buffered bytes are unaffected by later mode changes.
  always_comb begin
    push_data = databus;
    if (mode == 2'b01 && databus >= 8'h61 && databus <= 8'h7A)
      push_data = databus - 8'h20;
  end

  always_comb begin
    iocs   = 1'b0;
    iorw   = 1'b1;
    ioaddr = 2'b00;
    dout   = 8'h00;
    case (state)
      S_CFG_LO: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = 2'b10;
        dout   = div_sel[7:0];
      end
      S_CFG_HI: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = 2'b11;
        dout   = div_sel[15:8];
      end
      S_RD: begin
        iocs = 1'b1;
      end
      S_WR: begin
        iocs = 1'b1;
        iorw = 1'b0;
        dout = mem[rd_ptr];
      end
      default: ;
    endcase
  end

  assign databus = (iocs && !iorw) ? dout : 8'hzz;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CFG_WAIT;
      cfg_q      <= 2'b00;
      cfg_valid  <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      ovf        <= 1'b0;
      rx_total   <= 16'd0;
    end else begin
      if (clr_ovf)
        ovf <= 1'b0;
      case (state)
        S_CFG_WAIT: begin
          if (tbr) begin
            cfg_q <= br_cfg;
            state <= S_CFG_LO;
          end
        end
        S_CFG_LO: state <= S_CFG_HI;
        S_CFG_HI: begin
          cfg_valid <= 1'b1;
          state     <= S_IDLE;
        end
        S_IDLE: begin
          if (br_cfg != cfg_q) begin
            cfg_valid <= 1'b0;
            state     <= S_CFG_WAIT;
          end else if (rda) begin
            state <= S_RD;
          end else if (tbr && fifo_count != '0 && mode != 2'b11) begin
            state <= S_WR;
          end
        end
        S_RD: begin
          rx_total <= rx_total + 16'd1;
          if (mode != 2'b10) begin
            if (full) begin
              ovf <= 1'b1;
            end else begin
              wr_ptr     <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
              fifo_count <= fifo_count + CNT_W'(1);
            end
          end
          state <= S_GAP;
        end
        S_WR: begin
          rd_ptr     <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
          fifo_count <= fifo_count - CNT_W'(1);
          state      <= S_GAP;
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_CFG_WAIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spart_echo_ctrl.sv
// tb_spart_echo_ctrl: directed scenario bench for spart_echo_ctrl with a simple SPART bus model.
// Revision 1.0
`default_nettype none

module tb_spart_echo_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  br_cfg;
  logic [1:0]  mode;
  logic        clr_ovf;
  logic        rda;
  logic        tbr;
  logic        iocs;
  logic        iorw;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;
  logic [3:0]  fifo_count;
  logic        ovf;
  logic [15:0] rx_total;
  logic        cfg_valid;
  logic [7:0]  rx_byte;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] wr_q[$];
  int         wr_cyc[$];
  int         rd_cyc[$];

  spart_echo_ctrl #(.CLK_HZ(50_000_000), .DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .mode(mode), .clr_ovf(clr_ovf),
    .rda(rda), .tbr(tbr), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .fifo_count(fifo_count), .ovf(ovf),
    .rx_total(rx_total), .cfg_valid(cfg_valid)
  );

  always #5 clk = ~clk;

  // SPART side drives the bus only while the controller reads.
  assign databus = (iocs && iorw) ? rx_byte : 8'hzz;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (iocs === 1'b1 && iorw === 1'b0) begin
      wr_q.push_back({ioaddr, databus});
      wr_cyc.push_back(cyc);
    end
    if (iocs === 1'b1 && iorw === 1'b1)
      rd_cyc.push_back(cyc);
  end

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
    rd_cyc.delete();
  endtask

  // Called at a negedge; returns at the negedge of the GAP cycle following the read.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_byte = b;
    rda = 1'b1;
    while (!(iocs === 1'b1 && iorw === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: byte %02h not read within %0d cycles", b, n);
    end
    rda = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_writes(input string name, input logic [9:0] exp[$]);
    checks++;
    if (wr_q.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d writes, expected %0d", name, wr_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got addr/data %03h, expected %03h", name, i, wr_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] exp[$];
    rst = 1'b1; br_cfg = 2'b00; mode = 2'b00; clr_ovf = 1'b0;
    rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL rst_iocs: got %b expected 0", iocs); end
    checks++; if (iorw !== 1'b1) begin errors++; $display("FAIL rst_iorw: got %b expected 1", iorw); end
    checks++; if (ioaddr !== 2'b00) begin errors++; $display("FAIL rst_ioaddr: got %b expected 00", ioaddr); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    checks++; if (rx_total !== 16'd0) begin errors++; $display("FAIL rst_rx_total: got %0d expected 0", rx_total); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rst_cfg_valid: got %b expected 0", cfg_valid); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL cfg_wait_tbr: got iocs %b expected 0", iocs); end
    clear_log();
    tbr = 1'b1;
    repeat (6) @(negedge clk);
    exp = '{10'h28B, 10'h302};
    check_writes("cfg4800", exp);
    checks++;
    if (wr_cyc.size() == 2 && wr_cyc[1] != wr_cyc[0] + 1) begin
      errors++; $display("FAIL cfg_b2b: got cycles %0d,%0d expected consecutive", wr_cyc[0], wr_cyc[1]);
    end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL cfg_valid_set: got %b expected 1", cfg_valid); end
  endtask

  task automatic test_echo();
    logic [9:0] exp[$];
    mode = 2'b00;
    clear_log();
    send_byte(8'h41);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL echo_count1: got %0d expected 1", fifo_count); end
    repeat (6) @(negedge clk);
    exp = '{10'h041};
    check_writes("echo", exp);
    checks++;
    if (wr_cyc.size() != 1 || rd_cyc.size() != 1 || wr_cyc[0] - rd_cyc[0] != 3) begin
      errors++; $display("FAIL echo_latency: got %0d writes %0d reads, expected write 3 cycles after read", wr_cyc.size(), rd_cyc.size());
    end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL echo_count0: got %0d expected 0", fifo_count); end
    checks++; if (rx_total !== 16'd1) begin errors++; $display("FAIL echo_rx_total: got %0d expected 1", rx_total); end
  endtask

  task automatic test_upper();
    logic [9:0] exp[$];
    mode = 2'b01;
    clear_log();
    send_byte(8'h61);
    send_byte(8'h7A);
    send_byte(8'h5B);
    repeat (15) @(negedge clk);
    exp = '{10'h041, 10'h05A, 10'h05B};
    check_writes("upper", exp);
    checks++; if (rx_total !== 16'd4) begin errors++; $display("FAIL upper_rx_total: got %0d expected 4", rx_total); end
  endtask

  task automatic test_hold_overflow();
    logic [9:0] exp[$];
    mode = 2'b11;
    clear_log();
    for (int i = 0; i < DEPTH + 2; i++) send_byte(8'h10 + 8'(i));
    repeat (4) @(negedge clk);
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL hold_no_writes: got %0d writes expected 0", wr_q.size()); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL hold_count: got %0d expected 8", fifo_count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL hold_ovf: got %b expected 1", ovf); end
    checks++; if (rx_total !== 16'd14) begin errors++; $display("FAIL hold_rx_total: got %0d expected 14", rx_total); end
    mode = 2'b00;
    repeat (40) @(negedge clk);
    exp = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016, 10'h017};
    check_writes("drain", exp);
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", fifo_count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
  endtask

  task automatic test_reprogram();
    logic [9:0] exp[$];
    mode = 2'b11;
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    repeat (2) @(negedge clk);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL reprog_count3: got %0d expected 3", fifo_count); end
    clear_log();
    br_cfg = 2'b11;
    mode = 2'b00;
    send_byte(8'hA3);
    repeat (20) @(negedge clk);
    exp = '{10'h251, 10'h300, 10'h0A0, 10'h0A1, 10'h0A2, 10'h0A3};
    check_writes("reprog", exp);
    checks++;
    if (wr_cyc.size() < 2 || rd_cyc.size() != 1 || rd_cyc[0] <= wr_cyc[1]) begin
      errors++; $display("FAIL reprog_order: got %0d reads, expected one read after divisor high write", rd_cyc.size());
    end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL reprog_cfg_valid: got %b expected 1", cfg_valid); end
    checks++; if (rx_total !== 16'd18) begin errors++; $display("FAIL reprog_rx_total: got %0d expected 18", rx_total); end
  endtask

  task automatic test_reset_mid_write();
    logic [9:0] exp[$];
    mode = 2'b11;
    send_byte(8'hB0);
    send_byte(8'hB1);
    repeat (2) @(negedge clk);
    checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL rstwr_count2: got %0d expected 2", fifo_count); end
    mode = 2'b00;
    @(negedge clk);
    checks++; if (!(iocs === 1'b1 && iorw === 1'b0)) begin errors++; $display("FAIL rstwr_in_wr: got iocs %b iorw %b expected 1/0", iocs, iorw); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL rstwr_iocs: got %b expected 0", iocs); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rstwr_count: got %0d expected 0", fifo_count); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rstwr_cfg_valid: got %b expected 0", cfg_valid); end
    checks++; if (rx_total !== 16'd0) begin errors++; $display("FAIL rstwr_rx_total: got %0d expected 0", rx_total); end
    rst = 1'b0;
    clear_log();
    repeat (6) @(negedge clk);
    exp = '{10'h251, 10'h300};
    check_writes("rstwr_cfg", exp);
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL rstwr_cfg_valid_set: got %b expected 1", cfg_valid); end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_upper();
    test_hold_overflow();
    test_reprogram();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
